// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial WIDTH-bit add/sub built on one shared external 4-bit CLA.
// Define ALU_SEQ_FLAGS_EN to compute zero/negative/overflow flags at commit.
module alu_nibble_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic [3:0]       cla_a,
    output logic [3:0]       cla_b,
    output logic             cla_cin,
    input  logic [3:0]       cla_s,
    input  logic             cla_cout,
    input  logic             cla_c3
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("WIDTH must be a positive multiple of 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [IW-1:0]     idx;
    logic              cr;
    logic [N-1:0][3:0] opa;
    logic [N-1:0][3:0] opb;
    logic [N-1:0][3:0] acc;
    logic [N-1:0][3:0] acc_nxt;
    logic              last;

    assign last = (idx == LAST);
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Accumulator with the current adder nibble merged in, so the commit
    // edge can publish the full result without an extra cycle.
    always_comb begin
        acc_nxt      = acc;
        acc_nxt[idx] = cla_s;
    end

    always_comb begin
        cla_a   = '0;
        cla_b   = '0;
        cla_cin = 1'b0;
        if (state == RUN) begin
            cla_a   = opa[idx];
            cla_b   = opb[idx];
            cla_cin = cr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            cr     <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            result <= '0;
            flag_c <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        cr    <= sub;
                        idx   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    cr  <= cla_cout;
                    if (last) begin
                        result <= acc_nxt;
                        flag_c <= cla_cout;
                        state  <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
        end else if (state == RUN && last) begin
            flag_z <= (acc_nxt == '0);
            flag_n <= acc_nxt[N-1][3];
            flag_v <= cla_cout ^ cla_c3;
        end
    end
`else
    logic unused_c3;
    assign unused_c3 = cla_c3;
    assign flag_z    = 1'b0;
    assign flag_n    = 1'b0;
    assign flag_v    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: WIDTH=8 and WIDTH=16 instances, each
// wired to a behavioural 4-bit CLA, checked against an arithmetic model.
module tb_alu_nibble_sequencer;

`ifdef ALU_SEQ_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       st8, sb8, busy8, done8, c8, z8, n8, v8, ci8, co8, c38;
    logic [7:0] a8, b8, r8;
    logic [3:0] ca8, cb8, s8;

    logic        st16, sb16, busy16, done16, c16, z16, n16, v16, ci16, co16, c316;
    logic [15:0] a16, b16, r16;
    logic [3:0]  ca16, cb16, s16;

    alu_nibble_sequencer #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(st8), .sub(sb8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(r8), .flag_c(c8),
        .flag_z(z8), .flag_n(n8), .flag_v(v8),
        .cla_a(ca8), .cla_b(cb8), .cla_cin(ci8),
        .cla_s(s8), .cla_cout(co8), .cla_c3(c38)
    );

    alu_nibble_sequencer #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(st16), .sub(sb16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(r16), .flag_c(c16),
        .flag_z(z16), .flag_n(n16), .flag_v(v16),
        .cla_a(ca16), .cla_b(cb16), .cla_cin(ci16),
        .cla_s(s16), .cla_cout(co16), .cla_c3(c316)
    );

    // Behavioural shared adders: sum, carry out of bit 3, carry into bit 3
    int t8, t8l, t16, t16l;
    assign t8   = int'(ca8) + int'(cb8) + int'(ci8);
    assign t8l  = int'(ca8[2:0]) + int'(cb8[2:0]) + int'(ci8);
    assign s8   = 4'(t8);
    assign co8  = (t8 >= 16);
    assign c38  = (t8l >= 8);
    assign t16  = int'(ca16) + int'(cb16) + int'(ci16);
    assign t16l = int'(ca16[2:0]) + int'(cb16[2:0]) + int'(ci16);
    assign s16  = 4'(t16);
    assign co16 = (t16 >= 16);
    assign c316 = (t16l >= 8);

    int nerr = 0;
    int nchk = 0;

    typedef struct {
        logic [15:0] r;
        logic        c, z, n, v;
    } res_t;

    typedef struct {
        logic       s;
        logic [7:0] a, b, r;
        logic       c, z, n, v;
    } vec_t;

    function automatic res_t model(int w, bit s, int a, int b);
        res_t   res;
        longint m, sum, sa, sb, ideal;
        m      = longint'(1) << w;
        sum    = s ? longint'(a) + (m - longint'(b)) : longint'(a) + longint'(b);
        res.r  = 16'(sum % m);
        res.c  = (sum >= m);
        res.z  = ((sum % m) == 0);
        res.n  = ((sum % m) >= m / 2);
        sa     = (a >= m / 2) ? a - m : longint'(a);
        sb     = (b >= m / 2) ? b - m : longint'(b);
        ideal  = s ? sa - sb : sa + sb;
        res.v  = (ideal >= m / 2) || (ideal < -(m / 2));
        return res;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output logic [3:0] fa, output logic [3:0] fb,
                       output logic fc);
        st8 = 1'b1; sb8 = s; a8 = a; b8 = b;
        tick();
        st8 = 1'b0;
        fa = ca8; fb = cb8; fc = ci8;
        lat = 0;
        while (!done8 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic op16(input logic s, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output logic [3:0] cins);
        int k;
        st16 = 1'b1; sb16 = s; a16 = a; b16 = b;
        tick();
        st16 = 1'b0;
        cins = '0;
        lat = 0;
        k = 0;
        while (!done16 && lat < 20) begin
            if (busy16 && k < 4) cins[k] = ci16;
            k++;
            tick();
            lat++;
        end
    endtask

    task automatic check8(input string tag, input res_t e, input int lat);
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_res"}, r8, e.r[7:0]);
        chk({tag, "_c"}, c8, e.c);
        chk({tag, "_z"}, z8, FL & e.z);
        chk({tag, "_n"}, n8, FL & e.n);
        chk({tag, "_v"}, v8, FL & e.v);
    endtask

    vec_t        vt[5];
    int          lat, gap, nd;
    logic [3:0]  fa, fb, cins;
    logic        fc;
    res_t        e;
    logic [7:0]  ra, rb;
    logic [15:0] wa, wb;
    logic        rs;

    initial begin
        vt[0] = '{1'b0, 8'h3C, 8'h45, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[1] = '{1'b1, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[3] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[4] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b1;
        st8 = 0; sb8 = 0; a8 = 0; b8 = 0;
        st16 = 0; sb16 = 0; a16 = 0; b16 = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_res", r8, 0);
        chk("rst_flags", {c8, z8, n8, v8}, 0);
        chk("rst_cla", {ca8, cb8, ci8}, 0);
        chk("rst_res16", r16, 0);

        for (int i = 0; i < 5; i++) begin
            op8(vt[i].s, vt[i].a, vt[i].b, lat, fa, fb, fc);
            chk("vec_first_a", fa, {28'd0, vt[i].a[3:0]});
            chk("vec_first_b", fb, vt[i].s ? {28'd0, ~vt[i].b[3:0]} : {28'd0, vt[i].b[3:0]});
            chk("vec_first_cin", fc, vt[i].s);
            chk("vec_lat", lat, 2);
            chk("vec_res", r8, vt[i].r);
            chk("vec_c", c8, vt[i].c);
            chk("vec_z", z8, FL & vt[i].z);
            chk("vec_n", n8, FL & vt[i].n);
            chk("vec_v", v8, FL & vt[i].v);
            chk("vec_quiet", {ca8, cb8, ci8}, 0);
            tick();
        end

        // start held through DONE issues a second op back-to-back
        st8 = 1'b1; sb8 = 1'b0; a8 = 8'h3C; b8 = 8'h45;
        tick();
        a8 = 8'h7F; b8 = 8'h01;
        tick();
        tick();
        chk("b2b_done1", done8, 1);
        chk("b2b_res1", r8, 8'h81);
        tick();
        st8 = 1'b0;
        chk("b2b_busy2", busy8, 1);
        chk("b2b_hold", r8, 8'h81);
        gap = 1;
        while (!done8 && gap < 20) begin
            if (busy8) chk("b2b_nopartial", r8, 8'h81);
            tick();
            gap++;
        end
        chk("b2b_gap", gap, 3);
        chk("b2b_res2", r8, 8'h80);
        chk("b2b_c2", c8, 0);
        chk("b2b_v2", v8, FL);
        tick();

        // start pulsed mid-RUN is dropped
        st8 = 1'b1; sb8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
        tick();
        a8 = 8'hFF; b8 = 8'hFF;
        tick();
        st8 = 1'b0;
        tick();
        chk("ign_done", done8, 1);
        chk("ign_res", r8, 8'h46);
        nd = 0;
        repeat (5) begin
            tick();
            if (done8) nd++;
        end
        chk("ign_nodone", nd, 0);

        // reset in the first RUN cycle aborts the op
        st8 = 1'b1; sb8 = 1'b0; a8 = 8'h55; b8 = 8'h11;
        tick();
        st8 = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_res", r8, 0);
        chk("abort_cla", {ca8, cb8, ci8}, 0);
        tick();
        rst = 1'b0;
        nd = 0;
        repeat (5) begin
            tick();
            if (done8) nd++;
        end
        chk("abort_nodone", nd, 0);
        op8(1'b0, 8'h55, 8'h11, lat, fa, fb, fc);
        check8("abort_fresh", model(8, 1'b0, 'h55, 'h11), lat);
        tick();

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            op8(rs, ra, rb, lat, fa, fb, fc);
            check8("rnd8", model(8, rs, int'(ra), int'(rb)), lat);
            if ($urandom_range(0, 1) == 0) tick();
        end

        op16(1'b0, 16'hFFFF, 16'h0001, lat, cins);
        chk("w16_lat", lat, 4);
        chk("w16_chain", cins, 4'b1110);
        chk("w16_res", r16, 0);
        chk("w16_c", c16, 1);
        chk("w16_z", z16, FL);
        chk("w16_nv", {n16, v16}, 0);
        tick();

        for (int i = 0; i < 12; i++) begin
            wa = 16'($urandom);
            wb = 16'($urandom);
            rs = 1'($urandom);
            op16(rs, wa, wb, lat, cins);
            e = model(16, rs, int'(wa), int'(wb));
            chk("rnd16_lat", lat, 4);
            chk("rnd16_res", r16, e.r);
            chk("rnd16_c", c16, e.c);
            chk("rnd16_zn", {z16, n16}, {FL & e.z, FL & e.n});
            chk("rnd16_v", v16, FL & e.v);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/alu_nibble_sequencer.md
# alu_nibble_sequencer

Multi-cycle controller that builds a WIDTH-bit add/subtract out of the single shared 4-bit carry-lookahead adder in the Mini-8-bit-CPU ALU. It latches operands on a start handshake and drives the adder one nibble per clock, least significant first. It chains the carry through a register, assembles the result, and reports carry, zero, negative and overflow flags to the CPU control unit. The adder itself stays a separate combinational instance; this block only drives its inputs and samples its outputs.

## Interface
- WIDTH, 8: operand/result width in bits. Must be a multiple of 4 and at least 4. Number of nibbles N = WIDTH/4.
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled on the rising edge.
- sub  input  1  0 = A+B, 1 = A−B; sampled with start.
- a, b  input  WIDTH  operands; sampled with start.
- busy  output  1  operation in progress; start is ignored while high.
- done  output  1  one-cycle pulse: result and flags are updated.
- result  output  WIDTH  last completed result; held until the next done.
- flag_c  output  1  carry out of MSB (for sub: 1 = no borrow).
- flag_z, flag_n, flag_v  output  1  zero, negative (result MSB), signed overflow.
- cla_a, cla_b  output  4  nibble inputs to the shared adder.
- cla_cin  output  1  adder carry-in (adder `op` input).
- cla_s  input  4  adder sum.
- cla_cout  input  1  adder carry out of bit 3.
- cla_c3  input  1  adder carry into bit 3 (the adder's `cout2`).

## Operation
- FSM states: IDLE, RUN, DONE. Nibble counter idx has ceil(log2 N) bits, minimum 1.
- IDLE, start=1:
  - latch a into opa and (sub ? ~b : b) into opb.
  - carry register cr ← sub; idx ← 0; go to RUN.
- RUN, every cycle:
  - cla_a = opa[4·idx+:4], cla_b = opb[4·idx+:4], cla_cin = cr.
  - On the edge: write cla_s into the accumulator nibble idx, cr ← cla_cout.
  - If idx = N−1: commit the accumulator to result, set the flags, go to DONE. Otherwise idx ← idx+1.
- Commit values: flag_c ← cla_cout; flag_v ← cla_cout XOR cla_c3 for the MSB nibble.
- DONE: done=1 for this cycle.
  - start=1: accept the new operation exactly as in IDLE and go to RUN.
  - Otherwise go to IDLE.
- Outputs outside RUN: cla_a = cla_b = 0 and cla_cin = 0, so the shared adder inputs are quiet.
- start in RUN: ignored and not queued.
- Arithmetic is modulo 2^WIDTH. result is updated only at commit; partial sums never appear on result.

## Timing
- Reset values:
  - state IDLE, idx 0, cr 0, busy 0, done 0.
  - result 0, all flags 0, cla_* outputs 0.
- start accepted at edge E0. busy=1 from E0 through E_N (N RUN cycles).
- Result, flags and done update together at edge E_N. done is high for one cycle.
- Latency is N clocks: 2 clocks for WIDTH=8. Back-to-back issue with start held in DONE gives a throughput of one op per N+1 clocks.
- busy is combinational from state (busy = state==RUN). done = state==DONE.
- Reset asserted mid-RUN aborts the operation immediately: all outputs return to reset values, and no done is produced.
- The adder path is combinational within the RUN cycle: cla_a/b/cin come from registers → external CLA → cla_s/cout captured at the same edge.

## Configuration
- ALU_SEQ_FLAGS_EN defined: flag_z, flag_n and flag_v are computed at commit.
  - flag_z ← (committed result == 0).
  - flag_n ← result[WIDTH−1].
  - flag_v as defined in Operation.
- ALU_SEQ_FLAGS_EN undefined: flag_z, flag_n and flag_v are tied to constant 0 and their logic is removed. flag_c is always present.

## Test plan
- Reset, then 0x3C+0x45 (sub=0): cla_a=C, cla_b=5 in the first RUN cycle. done at E2 with result=0x81, C=0, Z=0, N=1, V=1.
- 0x10−0x01 (sub=1): first-cycle cla_cin=1, cla_b=E. result=0x0F, C=1 (no borrow), Z=0, N=0, V=0.
- 0x00−0x01: result=0xFF, C=0, N=1. Then 0x80+0x80: result=0x00, C=1, Z=1, V=1.
- Back-to-back: start held through DONE with a second op 0x7F+0x01. The second done comes 3 clocks after the first, with result=0x80, V=1. A start pulsed mid-RUN is ignored (no extra done).
- Reset asserted in the first RUN cycle: busy=0, done never pulses, result=0x00. A fresh op then completes normally.
- WIDTH=16, 0xFFFF+0x0001: 4 RUN cycles with cla_cin chained 0,1,1,1. result=0x0000, C=1, Z=1. With the macro undefined, Z, N and V stay 0 throughout.
